// File: rtl/bellman_relax.sv
`default_nettype none
// bellman_relax: Bellman-Ford relaxation of a NODES x NODES adjacency matrix from a source vertex. Rev 1.0
// Optional build macro BELLMAN_EARLY_EXIT_EN: stop after the first round that makes no update.
module bellman_relax #(
   parameter int NODES        = 8,
   parameter int WEIGHT_WIDTH = 16,
   parameter int PRED_WIDTH   = 3
) (
   input  logic                                          clk,
   input  logic                                          relax_reset_n,
   input  logic                                          start,
   input  logic [PRED_WIDTH-1:0]                         src,
   input  logic [NODES-1:0][NODES-1:0][WEIGHT_WIDTH-1:0] adjmat,
   output logic [NODES-1:0][PRED_WIDTH+WEIGHT_WIDTH-1:0] vertmat,
   output logic                                          busy,
   output logic                                          done
);

   localparam int RW           = (NODES > 2) ? $clog2(NODES - 1) : 1;
   localparam int LAST_ROUND_I = (NODES > 1) ? NODES - 2 : 0;

   localparam logic [RW-1:0]         LAST_ROUND = RW'(LAST_ROUND_I);
   localparam logic [PRED_WIDTH-1:0] LAST_IDX   = PRED_WIDTH'(NODES - 1);

   localparam logic signed [WEIGHT_WIDTH-1:0] INF     = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
   localparam logic signed [WEIGHT_WIDTH-1:0] MIN     = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
   localparam logic signed [WEIGHT_WIDTH:0]   INF_EXT = {2'b00, {(WEIGHT_WIDTH-1){1'b1}}};
   localparam logic signed [WEIGHT_WIDTH:0]   MIN_EXT = {2'b11, {(WEIGHT_WIDTH-1){1'b0}}};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_RELAX = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]                     state_q, state_d;
   logic [PRED_WIDTH-1:0]          src_q, src_d;
   logic [PRED_WIDTH-1:0]          i_q, i_d;
   logic [PRED_WIDTH-1:0]          j_q, j_d;
   logic [RW-1:0]                  round_q, round_d;
   logic signed [WEIGHT_WIDTH-1:0] e_q, e_d;
   logic signed [WEIGHT_WIDTH-1:0] sw_q, sw_d;
   logic signed [WEIGHT_WIDTH-1:0] dw_q, dw_d;
   logic signed [WEIGHT_WIDTH-1:0] weight_q [NODES];
   logic signed [WEIGHT_WIDTH-1:0] weight_d [NODES];
   logic [PRED_WIDTH-1:0]          pred_q [NODES];
   logic [PRED_WIDTH-1:0]          pred_d [NODES];

   logic signed [WEIGHT_WIDTH:0]   w_sum;
   logic signed [WEIGHT_WIDTH:0]   w_dw_ext;
   logic signed [WEIGHT_WIDTH-1:0] w_sat;
   logic                           w_update;
   logic                           w_row_end;
   logic                           w_last_edge;
   logic                           w_finish;

`ifdef BELLMAN_EARLY_EXIT_EN
   logic changed_q, changed_d;
`endif

   // Sum kept one bit wider so overflow is visible before clamping back to WEIGHT_WIDTH.
   always_comb begin
      w_sum       = {e_q[WEIGHT_WIDTH-1], e_q} + {sw_q[WEIGHT_WIDTH-1], sw_q};
      w_dw_ext    = {dw_q[WEIGHT_WIDTH-1], dw_q};
      w_update    = (state_q == S_RELAX) && (e_q != '0) && (i_q != j_q) &&
                    (sw_q != INF) && (w_sum < w_dw_ext);
      w_row_end   = (j_q == LAST_IDX);
      w_last_edge = w_row_end && (i_q == LAST_IDX);
      if (w_sum > INF_EXT) begin
         w_sat = INF;
      end else if (w_sum < MIN_EXT) begin
         w_sat = MIN;
      end else begin
         w_sat = w_sum[WEIGHT_WIDTH-1:0];
      end
`ifdef BELLMAN_EARLY_EXIT_EN
      w_finish = w_last_edge && ((round_q == LAST_ROUND) || !(changed_q || w_update));
`else
      w_finish = w_last_edge && (round_q == LAST_ROUND);
`endif
   end

   always_ff @(posedge clk) begin
      if (!relax_reset_n) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         round_q <= '0;
         e_q     <= '0;
         sw_q    <= '0;
         dw_q    <= '0;
         for (int k = 0; k < NODES; k++) begin
            weight_q[k] <= INF;
            pred_q[k]   <= PRED_WIDTH'(k);
         end
`ifdef BELLMAN_EARLY_EXIT_EN
         changed_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         i_q      <= i_d;
         j_q      <= j_d;
         round_q  <= round_d;
         e_q      <= e_d;
         sw_q     <= sw_d;
         dw_q     <= dw_d;
         weight_q <= weight_d;
         pred_q   <= pred_d;
`ifdef BELLMAN_EARLY_EXIT_EN
         changed_q <= changed_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_INIT;
         S_INIT:         state_d = (NODES == 1) ? S_DONE : S_READ;
         S_READ:         state_d = S_RELAX;
         S_RELAX:        state_d = w_finish ? S_DONE : S_READ;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_INIT) || (state_q == S_READ) || (state_q == S_RELAX);
      done = (state_q == S_DONE);
   end

   // Index muxes are written as compare loops so NODES need not be a power of two.
   always_comb begin
      src_d    = src_q;
      i_d      = i_q;
      j_d      = j_q;
      round_d  = round_q;
      e_d      = e_q;
      sw_d     = sw_q;
      dw_d     = dw_q;
      weight_d = weight_q;
      pred_d   = pred_q;
`ifdef BELLMAN_EARLY_EXIT_EN
      changed_d = changed_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) src_d = src;
         end
         S_INIT: begin
            for (int k = 0; k < NODES; k++) begin
               weight_d[k] = (PRED_WIDTH'(k) == src_q) ? '0 : INF;
               pred_d[k]   = PRED_WIDTH'(k);
            end
            i_d     = '0;
            j_d     = '0;
            round_d = '0;
`ifdef BELLMAN_EARLY_EXIT_EN
            changed_d = 1'b0;
`endif
         end
         S_READ: begin
            for (int a = 0; a < NODES; a++) begin
               if (PRED_WIDTH'(a) == i_q) begin
                  sw_d = weight_q[a];
                  for (int b = 0; b < NODES; b++) begin
                     if (PRED_WIDTH'(b) == j_q) e_d = adjmat[a][b];
                  end
               end
            end
            for (int b = 0; b < NODES; b++) begin
               if (PRED_WIDTH'(b) == j_q) dw_d = weight_q[b];
            end
         end
         S_RELAX: begin
            for (int k = 0; k < NODES; k++) begin
               if (w_update && (PRED_WIDTH'(k) == j_q)) begin
                  weight_d[k] = w_sat;
                  pred_d[k]   = i_q;
               end
            end
`ifdef BELLMAN_EARLY_EXIT_EN
            changed_d = w_last_edge ? 1'b0 : (changed_q || w_update);
`endif
            if (w_row_end) begin
               j_d = '0;
               if (i_q == LAST_IDX) begin
                  i_d     = '0;
                  round_d = round_q + RW'(1);
               end else begin
                  i_d = i_q + PRED_WIDTH'(1);
               end
            end else begin
               j_d = j_q + PRED_WIDTH'(1);
            end
         end
         default: begin
         end
      endcase
   end

   generate
      for (genvar g = 0; g < NODES; g++) begin : g_vert
         assign vertmat[g] = {pred_q[g], weight_q[g]};
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bellman_relax.sv
`default_nettype none
// tb_bellman_relax: directed vector table plus hand sequences for bellman_relax (NODES=4).
module tb_bellman_relax;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int P     = 3;
   localparam int W8    = 8;
   localparam int LIMIT = 2000;
   localparam logic [15:0] INF = 16'h7FFF;
`ifdef BELLMAN_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [N-1:0][N-1:0][W-1:0] adj;
      logic [P-1:0]               src;
      int                         lat_fix;
      int                         lat_early;
      logic [N-1:0][W-1:0]        w;
      logic [N-1:0][P-1:0]        p;
   } vec_t;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       start;
   logic [P-1:0]               src;
   logic [N-1:0][N-1:0][W-1:0] adjmat;
   logic [N-1:0][P+W-1:0]      vertmat;
   logic                       busy;
   logic                       done;

   logic                        start2;
   logic [P-1:0]                src2;
   logic [N-1:0][N-1:0][W8-1:0] adj2;
   logic [N-1:0][P+W8-1:0]      vert2;
   logic                        busy2;
   logic                        done2;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs [6];

   bellman_relax #(.NODES(N), .WEIGHT_WIDTH(W), .PRED_WIDTH(P)) dut (
      .clk(clk), .relax_reset_n(rst_n), .start(start), .src(src),
      .adjmat(adjmat), .vertmat(vertmat), .busy(busy), .done(done)
   );

   bellman_relax #(.NODES(N), .WEIGHT_WIDTH(W8), .PRED_WIDTH(P)) dut8 (
      .clk(clk), .relax_reset_n(rst_n), .start(start2), .src(src2),
      .adjmat(adj2), .vertmat(vert2), .busy(busy2), .done(done2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0][W-1:0] pw(input int a, input int b, input int c, input int d);
      logic [N-1:0][W-1:0] r;
      r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
      return r;
   endfunction

   function automatic logic [N-1:0][P-1:0] pp(input int a, input int b, input int c, input int d);
      logic [N-1:0][P-1:0] r;
      r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c); r[3] = 3'(d);
      return r;
   endfunction

   task automatic launch(input logic [N-1:0][N-1:0][W-1:0] adj, input logic [P-1:0] s);
      @(negedge clk);
      adjmat = adj;
      src    = s;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges since the start edge until done is seen (c0 edges already elapsed).
   task automatic wait_done(input int c0, output int cyc);
      cyc = c0;
      while (cyc < LIMIT) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done) break;
      end
   endtask

   task automatic check_table(input string tag, input logic [N-1:0][W-1:0] w,
                              input logic [N-1:0][P-1:0] p);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s_w%0d", tag, k), {16'h0, vertmat[k][W-1:0]}, {16'h0, w[k]});
         check($sformatf("%s_p%0d", tag, k), {29'h0, vertmat[k][P+W-1:W]}, {29'h0, p[k]});
      end
   endtask

   initial begin
      int cyc;

      vecs[0].adj = '0; vecs[0].adj[0][1] = 16'd5; vecs[0].adj[1][2] = 16'hFFFD;
      vecs[0].src = 3'd0; vecs[0].lat_fix = 97; vecs[0].lat_early = 65;
      vecs[0].w = pw(0, 5, 2, 32767); vecs[0].p = pp(0, 0, 1, 3);

      vecs[1].adj = '0; vecs[1].adj[0][1] = 16'd1; vecs[1].adj[1][2] = 16'hFFFE;
      vecs[1].adj[2][0] = 16'hFFFF;
      vecs[1].src = 3'd0; vecs[1].lat_fix = 97; vecs[1].lat_early = 97;
      vecs[1].w = pw(-6, -3, -5, 32767); vecs[1].p = pp(2, 0, 1, 3);

      vecs[2].adj = '0; vecs[2].adj[0][1] = 16'd4;
      vecs[2].src = 3'd2; vecs[2].lat_fix = 97; vecs[2].lat_early = 33;
      vecs[2].w = pw(32767, 32767, 0, 32767); vecs[2].p = pp(0, 1, 2, 3);

      vecs[3].adj = '0; vecs[3].adj[0][1] = 16'd4; vecs[3].adj[2][3] = 16'd1;
      vecs[3].src = 3'd5; vecs[3].lat_fix = 97; vecs[3].lat_early = 33;
      vecs[3].w = pw(32767, 32767, 32767, 32767); vecs[3].p = pp(0, 1, 2, 3);

      vecs[4].adj = '0; vecs[4].adj[3][2] = 16'd1; vecs[4].adj[2][1] = 16'd1;
      vecs[4].adj[1][0] = 16'd1;
      vecs[4].src = 3'd3; vecs[4].lat_fix = 97; vecs[4].lat_early = 97;
      vecs[4].w = pw(3, 2, 1, 0); vecs[4].p = pp(1, 2, 3, 3);

      vecs[5].adj = '0; vecs[5].adj[0][1] = 16'd10; vecs[5].adj[0][2] = 16'd2;
      vecs[5].adj[2][1] = 16'd3; vecs[5].adj[1][3] = 16'd1;
      vecs[5].adj[1][1] = 16'hFFFB; vecs[5].adj[3][3] = 16'hFFFF;
      vecs[5].src = 3'd0; vecs[5].lat_fix = 97; vecs[5].lat_early = 97;
      vecs[5].w = pw(0, 5, 2, 6); vecs[5].p = pp(0, 2, 0, 1);

      rst_n  = 1'b0;
      start  = 1'b0;
      src    = '0;
      adjmat = '0;
      start2 = 1'b0;
      src2   = '0;
      adj2   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check_table("rst", pw(32767, 32767, 32767, 32767), pp(0, 1, 2, 3));
      @(negedge clk) rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         launch(vecs[v].adj, vecs[v].src);
         check($sformatf("v%0d_busy", v), {31'h0, busy}, 32'h1);
         check($sformatf("v%0d_done_low", v), {31'h0, done}, 32'h0);
         wait_done(0, cyc);
         check($sformatf("v%0d_latency", v), cyc, EARLY ? vecs[v].lat_early : vecs[v].lat_fix);
         check($sformatf("v%0d_busy_end", v), {31'h0, busy}, 32'h0);
         check_table($sformatf("v%0d", v), vecs[v].w, vecs[v].p);
      end

      // start while busy with a different src must be ignored
      launch(vecs[0].adj, 3'd0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      src   = 3'd2;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(10, cyc);
      check("busy_start_latency", cyc, EARLY ? 65 : 97);
      check_table("busy_start", vecs[0].w, vecs[0].p);

      // reset in the middle of a run
      launch(vecs[0].adj, 3'd0);
      repeat (39) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_done", {31'h0, done}, 32'h0);
      for (int k = 0; k < N; k++)
         check($sformatf("midrst_w%0d", k), {16'h0, vertmat[k][W-1:0]}, {16'h0, INF});
      @(negedge clk) rst_n = 1'b1;
      launch(vecs[0].adj, 3'd0);
      wait_done(0, cyc);
      check("after_rst_latency", cyc, EARLY ? 65 : 97);
      check_table("after_rst", vecs[0].w, vecs[0].p);

      // 8-bit saturation on the second instance
      @(negedge clk);
      adj2       = '0;
      adj2[0][1] = 8'h9C;
      adj2[1][2] = 8'h9C;
      src2       = 3'd0;
      start2     = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      cyc = 0;
      while (cyc < LIMIT) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done2) break;
      end
      check("sat_latency", cyc, 97);
      check("sat_w0", {24'h0, vert2[0][W8-1:0]}, 32'h00);
      check("sat_w1", {24'h0, vert2[1][W8-1:0]}, 32'h9C);
      check("sat_w2", {24'h0, vert2[2][W8-1:0]}, 32'h80);
      check("sat_w3", {24'h0, vert2[3][W8-1:0]}, 32'h7F);
      check("sat_p1", {29'h0, vert2[1][P+W8-1:W8]}, 32'h0);
      check("sat_p2", {29'h0, vert2[2][P+W8-1:W8]}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
